// File: rtl/ext_data_memory_pkg.sv
// Shared definitions for the external line memory model: bus widths and FSM encoding.
package ext_data_memory_pkg;

    localparam int unsigned LINE_BITS        = 256;
    localparam int unsigned ADDR_BITS        = 32;
    localparam int unsigned LINE_OFFSET_BITS = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

endpackage

// File: rtl/ext_data_memory_line_ram.sv
// DEPTH x LINE_BITS line store: clocked write, combinational read, no reset.
module line_ram
    import ext_data_memory_pkg::*;
#(
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned IDX_BITS = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [IDX_BITS-1:0]  idx,
    input  logic [LINE_BITS-1:0] wdata,
    output logic [LINE_BITS-1:0] rdata
);

    logic [LINE_BITS-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/ext_data_memory.sv
// Responder for the cache's 256-bit line handshake: one request at a time, ack after a fixed latency.
module ext_data_memory
    import ext_data_memory_pkg::*;
#(
    parameter int unsigned DEPTH   = 512,
    parameter int unsigned LATENCY = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_i,
    input  logic                 enable_i,
    input  logic                 write_i,
    input  logic [LINE_BITS-1:0] data_i,
    output logic                 ack_o,
    output logic [LINE_BITS-1:0] data_o
);

    localparam int unsigned IDX_BITS = $clog2(DEPTH);
    localparam int unsigned CNT_BITS = $clog2(LATENCY) + 1;
    localparam logic [CNT_BITS-1:0] CNT_LOAD = CNT_BITS'(LATENCY - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam bit SINGLE_CYCLE = (LATENCY == 1);

    state_e               state;
    logic [CNT_BITS-1:0]  cnt;
    logic [IDX_BITS-1:0]  idx_q;
    logic                 wr_q;
    logic [LINE_BITS-1:0] wdata_q;

    logic [IDX_BITS-1:0]  addr_idx_c;
    logic [IDX_BITS-1:0]  ram_idx_c;
    logic [LINE_BITS-1:0] ram_wdata_c;
    logic [LINE_BITS-1:0] ram_rdata;
    logic                 ram_we_c;
    logic                 accept_c;
    logic                 enter_ack_c;
    logic                 wr_now_c;
    logic                 unused_addr_bits_c;

    assign addr_idx_c = addr_i[LINE_OFFSET_BITS +: IDX_BITS];
    assign unused_addr_bits_c = ^{addr_i[LINE_OFFSET_BITS-1:0],
                                  addr_i[ADDR_BITS-1:LINE_OFFSET_BITS+IDX_BITS]};

    assign accept_c    = (state == ST_IDLE) && enable_i;
    assign enter_ack_c = (accept_c && SINGLE_CYCLE) || ((state == ST_BUSY) && (cnt == CNT_ONE));

    // Direction of the access completing this edge; an unknown write_i resolves to a read.
    always_comb begin
        wr_now_c = wr_q;
        if (state == ST_IDLE) begin
            wr_now_c = 1'b0;
            if (write_i) begin
                wr_now_c = 1'b1;
            end
        end
    end

    // The bypass from the live inputs only matters for the single-cycle latency build.
    assign ram_idx_c   = (state == ST_IDLE) ? addr_idx_c : idx_q;
    assign ram_wdata_c = (state == ST_IDLE) ? data_i     : wdata_q;
    assign ram_we_c    = enter_ack_c && wr_now_c;

    line_ram #(
        .DEPTH    (DEPTH),
        .IDX_BITS (IDX_BITS)
    ) u_line_ram (
        .clk   (clk),
        .we    (ram_we_c),
        .idx   (ram_idx_c),
        .wdata (ram_wdata_c),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ack_o   <= 1'b0;
            data_o  <= '0;
            cnt     <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            ack_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        idx_q   <= addr_idx_c;
                        wr_q    <= 1'b0;
                        if (write_i) begin
                            wr_q <= 1'b1;
                        end
                        wdata_q <= data_i;
                        cnt     <= CNT_LOAD;
                        state   <= SINGLE_CYCLE ? ST_ACK : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
            // Completion: the write commits in the RAM, a read latches the line.
            if (enter_ack_c) begin
                ack_o <= 1'b1;
                if (!wr_now_c) begin
                    data_o <= ram_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_data_memory.sv
// Directed bench for ext_data_memory: default build plus a LATENCY=1 build.
module tb_ext_data_memory;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  addr0, addr1;
    logic         en0, en1, wr0, wr1;
    logic [255:0] din0, din1;
    logic         ack0, ack1;
    logic [255:0] dout0, dout1;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    localparam logic [255:0] P_DEAD = {8{32'hDEAD_BEEF}};
    localparam logic [255:0] P2     = {8{32'h0123_4567}};
    localparam logic [255:0] P3     = {4{64'hCAFE_F00D_1234_5678}};
    localparam logic [255:0] PA     = {8{32'hA5A5_0001}};
    localparam logic [255:0] PB     = {8{32'h5A5A_0002}};
    localparam logic [255:0] PQ     = {8{32'h1111_2222}};
    localparam logic [255:0] JUNK   = {8{32'hFFFF_FFFF}};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ext_data_memory #(.DEPTH(512), .LATENCY(10)) u_dut (
        .clk(clk), .rst(rst), .addr_i(addr0), .enable_i(en0), .write_i(wr0),
        .data_i(din0), .ack_o(ack0), .data_o(dout0)
    );

    ext_data_memory #(.DEPTH(512), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .addr_i(addr1), .enable_i(en1), .write_i(wr1),
        .data_i(din1), .ack_o(ack1), .data_o(dout1)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic ack_sel(input int sel);
        return (sel == 1) ? ack1 : ack0;
    endfunction

    // One request; checks accept-to-ack edge count and one-cycle ack width, returns data_o at ack.
    task automatic req(input int sel, input logic [31:0] a, input logic w, input logic [255:0] d,
                       input bit mess, input int lat, input string tag, output logic [255:0] rd);
        int n;
        @(negedge clk);
        if (sel == 1) begin addr1 = a; wr1 = w; din1 = d; en1 = 1'b1; end
        else          begin addr0 = a; wr0 = w; din0 = d; en0 = 1'b1; end
        @(posedge clk); #1;
        n = 0;
        if (mess) begin
            @(negedge clk);
            addr0 = 32'h0000_0080; wr0 = 1'b1; din0 = JUNK;
        end
        while (!ack_sel(sel) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, 256'(n + 1), 256'(lat));
        rd = (sel == 1) ? dout1 : dout0;
        @(negedge clk);
        if (sel == 1) en1 = 1'b0; else en0 = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_ackw"}, 256'(ack_sel(sel)), 256'(0));
    endtask

    initial begin
        logic [255:0] rd;
        int t [3];
        bit seen;
        int n;

        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] rd;
        logic [31:0]  nxt [3];
        logic [255:0] exp_rd [3];
        int t [3];
        int n;
        bit seen;

        rst = 1'b1;
        addr0 = 32'h40; wr0 = 1'b0; din0 = '0; en0 = 1'b1;
        addr1 = 32'h40; wr1 = 1'b0; din1 = '0; en1 = 1'b1;

        // 1: reset with enable held
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("rst_ack", 256'(ack0), 256'(0));
            chk("rst_data", dout0, 256'(0));
        end
        chk("rst_ack1", 256'(ack1), 256'(0));
        @(negedge clk);
        rst = 1'b0; en0 = 1'b0; en1 = 1'b0;
        seen = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
            if (ack0 || ack1) seen = 1'b1;
        end
        chk("rst_noaccept", 256'(seen), 256'(0));

        // 2: write then read, latency 10
        req(0, 32'h0000_0040, 1'b1, P_DEAD, 1'b0, 10, "wr40", rd);
        chk("wr40_hold", rd, 256'(0));
        req(0, 32'h0000_0040, 1'b0, JUNK, 1'b0, 10, "rd40", rd);
        chk("rd40_data", rd, P_DEAD);

        // 3: byte offset and index aliasing
        req(0, 32'h0000_0020, 1'b1, P2, 1'b0, 10, "wr20", rd);
        chk("wr20_hold", rd, P_DEAD);
        req(0, 32'h0000_003F, 1'b0, '0, 1'b0, 10, "rd3f", rd);
        chk("rd3f_data", rd, P2);
        req(0, 32'h0000_4020, 1'b0, '0, 1'b0, 10, "rd4020", rd);
        chk("rd4020_data", rd, P2);

        // 4: inputs ignored while busy
        req(0, 32'h0000_0080, 1'b1, P3, 1'b0, 10, "wr80", rd);
        req(0, 32'h0000_0040, 1'b0, '0, 1'b1, 10, "holdoff", rd);
        chk("holdoff_data", rd, P_DEAD);
        req(0, 32'h0000_0080, 1'b0, '0, 1'b0, 10, "rd80", rd);
        chk("rd80_data", rd, P3);

        // 5: back-to-back reads with enable held across ack
        nxt[0] = 32'h0000_0020; nxt[1] = 32'h0000_0080; nxt[2] = 32'h0;
        exp_rd[0] = P_DEAD; exp_rd[1] = P2; exp_rd[2] = P3;
        @(negedge clk);
        addr0 = 32'h0000_0040; wr0 = 1'b0; en0 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!ack0 && n < 40);
            t[k] = cyc;
            chk($sformatf("b2b%0d_data", k), dout0, exp_rd[k]);
            @(negedge clk);
            if (k == 2) en0 = 1'b0; else addr0 = nxt[k];
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_ackw", k), 256'(ack0), 256'(0));
        end
        chk("b2b_gap01", 256'(t[1] - t[0]), 256'(11));
        chk("b2b_gap12", 256'(t[2] - t[1]), 256'(11));

        // 6: reset aborts an in-flight write
        req(0, 32'h0000_0100, 1'b1, PA, 1'b0, 10, "wr100", rd);
        @(negedge clk);
        addr0 = 32'h0000_0100; wr0 = 1'b1; din0 = PB; en0 = 1'b1;
        @(posedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; en0 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (ack0) seen = 1'b1;
        end
        chk("abort_noack", 256'(seen), 256'(0));
        chk("abort_data0", dout0, 256'(0));
        req(0, 32'h0000_0100, 1'b0, '0, 1'b0, 10, "rd100", rd);
        chk("rd100_data", rd, PA);

        // LATENCY=1 build
        req(1, 32'h0000_0040, 1'b1, PQ, 1'b0, 1, "l1wr", rd);
        chk("l1wr_hold", rd, 256'(0));
        req(1, 32'h0000_0040, 1'b0, '0, 1'b0, 1, "l1rd", rd);
        chk("l1rd_data", rd, PQ);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
